word_align_deserializer: RTL

Receive-side counterpart of the low-power tree serializer. Takes the single-bit serial stream produced by the serializer, finds word boundaries by hunting for a sync word, and presents aligned parallel words with a one-cycle valid strobe. Sits directly downstream of the serializer's `SERIAL_OUT` and feeds parallel consumers.

---
 rtl/serdes_pkg.sv | 13 +
 rtl/deser_shift_reg.sv | 27 ++
 rtl/word_align_deserializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer / word-align deserializer pair.
package serdes_pkg;

  localparam int         SERDES_WIDTH = 8;
  localparam logic [7:0] SERDES_SYNC  = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// LSB-first receive shift register; exposes the post-edge value so the
// parent can detect a pattern completed by the bit arriving this cycle.
module deser_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             din,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // New bit enters at the MSB so a full word ends up with its first bit at [0].
  always_comb begin
    sr_d = {din, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign sr_next = sr_d;

endmodule

// File: rtl/word_align_deserializer.sv
// Hunts for a sync word in a serial stream, confirms it one word later,
// then emits aligned parallel words with a one-cycle valid strobe.
module word_align_deserializer
  import serdes_pkg::*;
#(
  parameter int               WIDTH     = SERDES_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SERDES_SYNC)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  input  logic             RESYNC,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             IS_SYNC,
  output logic             LOCKED
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_next;

  deser_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .CLK     (CLK),
    .RESET   (RESET),
    .din     (SERIAL_IN),
    .sr_next (sr_next)
  );

  deser_state_t     state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] par_out_q,   par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             is_sync_q,   is_sync_d;
  logic             locked_q,    locked_d;

  logic match;
  logic boundary;
  logic [CW-1:0] cnt_inc;

  assign match    = (sr_next == SYNC_WORD);
  assign boundary = (cnt_q == CW'(WIDTH - 1));
  assign cnt_inc  = boundary ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_out_d   = par_out_q;
    par_valid_d = 1'b0;
    is_sync_d   = 1'b0;
    if (RESYNC) begin
      // Drops any partial word; a match seen on this edge is not acted on.
      state_d = HUNT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          cnt_d = '0;
          if (match) state_d = VERIFY;
        end
        VERIFY: begin
          cnt_d = cnt_inc;
          if (boundary) state_d = match ? serdes_pkg::LOCKED : HUNT;
        end
        serdes_pkg::LOCKED: begin
          cnt_d = cnt_inc;
          if (boundary) begin
            par_out_d   = sr_next;
            par_valid_d = 1'b1;
            is_sync_d   = match;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
    locked_d = (state_d == serdes_pkg::LOCKED);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      is_sync_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      is_sync_q   <= is_sync_d;
      locked_q    <= locked_d;
    end
  end

  assign PAR_OUT   = par_out_q;
  assign PAR_VALID = par_valid_q;
  assign IS_SYNC   = is_sync_q;
  assign LOCKED    = locked_q;

endmodule
